ps2_direction_decoder: RTL and testbench

- Receive side of the PS/2 keyboard link that feeds the snake game logic.
- Deserialises PS/2 device-to-host frames and tracks E0/F0 prefixes.
- Translates arrow and WASD make codes into the `direction` bus, and Enter into the `reset_game` level consumed by the game.
- Sits between the keyboard pins and the snake logic, entirely in the clk_25 domain.

---
 rtl/ps2_direction_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 receiver that turns arrow/WASD/Enter keys into snake controls
//
// Purpose: deserialises PS/2 device-to-host frames in the clk_25 domain, tracks the
// E0 (extended) and F0 (break) prefixes, and maps key makes/breaks onto the snake
// direction bus and the reset_game level.
//
// Ports:
//   clk_25     in   system clock, all logic on rising edge
//   rst        in   asynchronous active-low reset
//   clk_ps2    in   PS/2 clock from keyboard (asynchronous)
//   data_ps2   in   PS/2 data from keyboard (asynchronous)
//   direction  out  current requested snake direction
//   reset_game out  high while Enter is held
//   scan_code  out  last correctly received byte
//   scan_valid out  one-cycle pulse per good byte
//   frame_err  out  one-cycle pulse per bad or abandoned frame

module ps2_direction_decoder #(
    parameter int                DIR_W          = 2,
    parameter logic [DIR_W-1:0]  DIR_UP         = 2'd0,
    parameter logic [DIR_W-1:0]  DIR_DOWN       = 2'd1,
    parameter logic [DIR_W-1:0]  DIR_LEFT       = 2'd2,
    parameter logic [DIR_W-1:0]  DIR_RIGHT      = 2'd3,
    parameter int                TIMEOUT_CYCLES = 5000,
    parameter int                TMO_W          = 13
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic             clk_ps2,
    input  logic             data_ps2,
    output logic [DIR_W-1:0] direction,
    output logic             reset_game,
    output logic [7:0]       scan_code,
    output logic             scan_valid,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Counter value one cycle before the timeout fires: the increment taking
    // it to TIMEOUT_CYCLES-1 is the cycle that abandons the frame.
    localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]       clk_sync_q;   // [0],[1] synchroniser, [2] previous synced value
    logic [1:0]       dat_sync_q;
    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic             ext_q;
    logic             brk_q;

    logic             fe;
    logic             data_bit;
    logic             timeout;
    logic             want_valid;
    logic [DIR_W-1:0] want;
    logic [DIR_W-1:0] dir_d;
    logic             rg_d;

    assign fe       = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = dat_sync_q[1];
    // A falling edge in the same cycle keeps the frame alive.
    assign timeout  = (state_q != S_IDLE) && !fe && (tmo_q == TMO_FIRE);

    function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
        if (d == DIR_UP)         return DIR_DOWN;
        else if (d == DIR_DOWN)  return DIR_UP;
        else if (d == DIR_LEFT)  return DIR_RIGHT;
        else                     return DIR_LEFT;
    endfunction

    // Key decode for the byte currently on scan_code, using the prefix state
    // accumulated from earlier bytes.
    always_comb begin
        want_valid = 1'b0;
        want       = direction;
        case ({ext_q, scan_code})
            {1'b1, 8'h75}, {1'b0, 8'h1D}: begin want_valid = 1'b1; want = DIR_UP;    end
            {1'b1, 8'h72}, {1'b0, 8'h1B}: begin want_valid = 1'b1; want = DIR_DOWN;  end
            {1'b1, 8'h6B}, {1'b0, 8'h1C}: begin want_valid = 1'b1; want = DIR_LEFT;  end
            {1'b1, 8'h74}, {1'b0, 8'h23}: begin want_valid = 1'b1; want = DIR_RIGHT; end
            default: ;
        endcase
        dir_d = direction;
        rg_d  = reset_game;
        // Reversal lock: the snake may not turn straight back on itself.
        if (!brk_q && want_valid && (want != opposite(direction)))
            dir_d = want;
        if (!ext_q && (scan_code == 8'h5A))
            rg_d = !brk_q;
    end

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], clk_ps2};
            dat_sync_q <= {dat_sync_q[0], data_ps2};
        end
    end

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            direction  <= DIR_RIGHT;
            reset_game <= 1'b0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state_q == S_IDLE || fe)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TMO_W'(1);

            // Decode of the previous good byte; a frame can never end in the
            // same cycle, so the bad-frame prefix clear below cannot collide.
            if (scan_valid) begin
                if (scan_code == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (scan_code == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    direction  <= dir_d;
                    reset_game <= rg_d;
                    ext_q      <= 1'b0;
                    brk_q      <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    // A high start bit is treated as a glitch.
                    if (fe && !data_bit) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (fe) begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fe) begin
                        parity_q <= data_bit;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (fe) begin
                        state_q <= S_IDLE;
                        if (data_bit && ((^shift_q) ^ parity_q)) begin
                            scan_code  <= shift_q;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (timeout) begin
                state_q   <= S_IDLE;
                frame_err <= 1'b1;
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - self-checking bench for ps2_direction_decoder
`timescale 1ns/1ps

module tb_ps2_direction_decoder;

    localparam int T    = 5000;
    localparam int HALF = 16;

    logic       clk_25 = 1'b0;
    logic       rst;
    logic       clk_ps2;
    logic       data_ps2;
    logic [1:0] direction;
    logic       reset_game;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    always #20 clk_25 = ~clk_25;

    ps2_direction_decoder #(
        .DIR_W(2), .DIR_UP(2'd0), .DIR_DOWN(2'd1), .DIR_LEFT(2'd2), .DIR_RIGHT(2'd3),
        .TIMEOUT_CYCLES(T), .TMO_W(13)
    ) dut (
        .clk_25(clk_25), .rst(rst), .clk_ps2(clk_ps2), .data_ps2(data_ps2),
        .direction(direction), .reset_game(reset_game), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: direction index 0..3 = up, down, left, right, so the
    // opposite direction is simply the index with bit 0 flipped.
    logic [1:0] m_dir;
    logic       m_rg, m_ext, m_brk;
    logic [7:0] m_code;
    logic [7:0] arrow_c [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] wasd_c  [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] pool    [11] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                                 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A};

    function automatic void model_reset();
        m_dir = 2'd3; m_rg = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00;
    endfunction

    function automatic void model_good(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_ext && b == 8'h5A) m_rg = !m_brk;
            if (!m_brk)
                for (int i = 0; i < 4; i++)
                    if ((m_ext ? arrow_c[i] : wasd_c[i]) == b && 2'(i) != (m_dir ^ 2'd1))
                        m_dir = 2'(i);
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input int bad);
        logic par;
        par = ~^b;
        if (bad == 1) par = ~par;
        return {(bad == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    endfunction

    // bad: 0 good frame, 1 wrong parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int bad, input int half);
        logic [10:0] bits;
        logic [1:0]  old_dir;
        logic        old_rg, good;
        bits = frame_bits(b, bad);
        for (int i = 0; i < 10; i++) begin
            data_ps2 = bits[i];
            repeat (half) @(negedge clk_25);
            clk_ps2 = 1'b0;
            repeat (half) @(negedge clk_25);
            clk_ps2 = 1'b1;
        end
        data_ps2 = bits[10];
        repeat (half) @(negedge clk_25);
        clk_ps2 = 1'b0;
        old_dir = m_dir; old_rg = m_rg; good = (bad == 0);
        if (good) model_good(b);
        else begin m_ext = 1'b0; m_brk = 1'b0; end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_25);
            if (k == 2) chk("valid_early", scan_valid, 0);
            if (k == 3) begin
                chk("scan_valid", scan_valid, good);
                chk("frame_err", frame_err, !good);
                chk("scan_code", scan_code, m_code);
                chk("dir_hold", direction, old_dir);
                chk("rg_hold", reset_game, old_rg);
            end
            if (k == 4) begin
                chk("valid_drop", scan_valid, 0);
                chk("err_drop", frame_err, 0);
                chk("direction", direction, m_dir);
                chk("reset_game", reset_game, m_rg);
            end
        end
        repeat (half - 4) @(negedge clk_25);
        clk_ps2 = 1'b1; data_ps2 = 1'b1;
        repeat (2 * half) @(negedge clk_25);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dir"}, direction, 2'd3);
        chk({tag, "_rg"}, reset_game, 0);
        chk({tag, "_code"}, scan_code, 8'h00);
        chk({tag, "_valid"}, scan_valid, 0);
        chk({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        logic [10:0] bits;
        int          k;
        bit          seen;
        logic [7:0]  b;
        int          bad;

        rst = 1'b0; clk_ps2 = 1'b1; data_ps2 = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_25);
        chk_reset_vals("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk_25);

        // 80 us bit period: 2000 clk_25 cycles per bit
        send_frame(8'h1D, 0, 1000);

        send_frame(8'hE0, 0, HALF); send_frame(8'h6B, 0, HALF);
        send_frame(8'hE0, 0, HALF); send_frame(8'hF0, 0, HALF); send_frame(8'h6B, 0, HALF);
        send_frame(8'h1D, 0, HALF); send_frame(8'h23, 0, HALF);
        send_frame(8'hE0, 0, HALF); send_frame(8'h6B, 0, HALF);
        send_frame(8'h1B, 0, HALF); send_frame(8'h1C, 0, HALF);
        chk("final_left", m_dir, 2'd2);

        send_frame(8'h5A, 1, HALF);
        send_frame(8'h5A, 0, HALF);
        send_frame(8'hF0, 0, HALF); send_frame(8'h5A, 0, HALF);
        send_frame(8'hE0, 0, HALF); send_frame(8'h5A, 2, HALF);
        send_frame(8'h74, 0, HALF);

        // Timeout: start bit plus four data bits, then the keyboard goes quiet.
        bits = frame_bits(8'hA5, 0);
        for (int i = 0; i < 5; i++) begin
            data_ps2 = bits[i];
            repeat (HALF) @(negedge clk_25);
            clk_ps2 = 1'b0;
            if (i < 4) begin
                repeat (HALF) @(negedge clk_25);
                clk_ps2 = 1'b1;
            end
        end
        seen = 1'b0;
        for (k = 1; k <= T + 50; k++) begin
            @(negedge clk_25);
            if (k == HALF) begin clk_ps2 = 1'b1; data_ps2 = 1'b1; end
            if (frame_err) begin seen = 1'b1; break; end
        end
        chk("tmo_seen", seen, 1);
        // two synchroniser cycles to see the edge, then TIMEOUT_CYCLES to the pulse
        chk("tmo_latency", k, T + 2);
        chk("tmo_no_valid", scan_valid, 0);
        @(negedge clk_25);
        chk("tmo_drop", frame_err, 0);
        m_ext = 1'b0; m_brk = 1'b0;
        repeat (2 * HALF) @(negedge clk_25);
        send_frame(8'h23, 0, HALF);

        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(0, 11);
            b   = (k < 11) ? pool[k] : 8'($urandom);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
            send_frame(b, bad, HALF);
        end

        // Reset during the parity bit while Enter is held.
        send_frame(8'h5A, 0, HALF);
        chk("rg_before_rst", reset_game, 1);
        bits = frame_bits(8'h1C, 0);
        for (int i = 0; i < 9; i++) begin
            data_ps2 = bits[i];
            repeat (HALF) @(negedge clk_25);
            clk_ps2 = 1'b0;
            repeat (HALF) @(negedge clk_25);
            clk_ps2 = 1'b1;
        end
        data_ps2 = bits[9];
        repeat (HALF / 2) @(negedge clk_25);
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(negedge clk_25);
        rst = 1'b1; clk_ps2 = 1'b1; data_ps2 = 1'b1;
        repeat (2 * HALF) @(negedge clk_25);
        send_frame(8'h1B, 0, HALF);
        chk("after_rst_down", direction, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
